// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer with flush and occupancy count.
// Optional same-cycle enq->deq forwarding when empty, enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int ILEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [ILEN-1:0]            enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [ILEN-1:0]            deq_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                flush_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          byp, push, pop;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count == '0) && enq_valid && !flush && !rst;
`else
  assign byp = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign enq_ready = rst || (count < CW'(DEPTH));
  assign deq_valid = !rst && !flush && ((count != '0) || byp);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign deq_pc    = !deq_valid ? '0 : (byp ? enq_pc    : head.pc);
  assign deq_instr = !deq_valid ? '0 : (byp ? enq_instr : head.instr);
`else
  assign deq_pc    = deq_valid ? head.pc    : '0;
  assign deq_instr = deq_valid ? head.instr : '0;
`endif

  // A forwarded entry that decode takes immediately is never written to storage.
  assign push = enq_valid && enq_ready && !flush && !rst && !(byp && deq_ready);
  assign pop  = deq_valid && deq_ready && !byp;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enq_pc, enq_instr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue holds expected entries and occupancy,
// every cycle's outputs are checked against it with immediate assertions.
module tb_fetch_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int ILEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            enq_valid, enq_ready, deq_valid, deq_ready, flush;
  logic [XLEN-1:0] enq_pc, deq_pc;
  logic [ILEN-1:0] enq_instr, deq_instr;
  logic [2:0]      count;
  logic [15:0]     flush_cnt;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [15:0] fc;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ILEN(ILEN)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .flush(flush), .count(count), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hA5A5_0000;
  endfunction

  // One clock: drive at posedge+1, check mid-cycle, update model, advance.
  task automatic step(input logic ev, input logic [63:0] pc, input logic dr, input logic fl);
    logic byp, exp_dv, enq_ok, deq_ok;
    logic [63:0] exp_pc;
    logic [31:0] exp_in;
    enq_valid = ev; enq_pc = pc; enq_instr = instr_of(pc); deq_ready = dr; flush = fl;
    #3;
    byp    = BYP && q.size() == 0 && ev && !fl;
    exp_dv = !fl && (q.size() != 0 || byp);
    exp_pc = 64'h0; exp_in = 32'h0;
    if (exp_dv) begin
      exp_pc = (q.size() != 0) ? q[0].pc    : pc;
      exp_in = (q.size() != 0) ? q[0].instr : instr_of(pc);
    end
    chk("enq_ready", 64'(enq_ready), 64'(q.size() < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
    chk("deq_pc",    deq_pc,         exp_pc);
    chk("deq_instr", 64'(deq_instr), 64'(exp_in));
    chk("count",     64'(count),     64'(q.size()));
    chk("flush_cnt", 64'(flush_cnt), 64'(fc));
    enq_ok = ev && q.size() < DEPTH && !fl;
    deq_ok = exp_dv && dr;
    if (fl) q.delete();
    else begin
      if (deq_ok && !byp) void'(q.pop_front());
      if (enq_ok && !(byp && dr)) q.push_back('{pc: pc, instr: instr_of(pc)});
    end
    if (fl && fc != 16'hFFFF) fc++;
    @(posedge clk); #1;
  endtask

  // Reset with enq/flush/deq also asserted to show rst overrides them.
  task automatic do_reset();
    rst = 1'b1; enq_valid = 1'b1; enq_pc = 64'h999; enq_instr = 32'h1; deq_ready = 1'b1; flush = 1'b1;
    #3;
    chk("rst_enq_ready", 64'(enq_ready), 64'h1);
    chk("rst_deq_valid", 64'(deq_valid), 64'h0);
    chk("rst_deq_pc",    deq_pc,         64'h0);
    chk("rst_deq_instr", 64'(deq_instr), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    q.delete(); fc = 16'h0;
    #3;
    chk("post_rst_count",     64'(count),     64'h0);
    chk("post_rst_flush_cnt", 64'(flush_cnt), 64'h0);
    chk("post_rst_deq_valid", 64'(deq_valid), 64'h0);
    chk("post_rst_deq_pc",    deq_pc,         64'h0);
    chk("post_rst_enq_ready", 64'(enq_ready), 64'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    enq_pc = '0; enq_instr = '0; fc = 16'h0;
    @(posedge clk); #1;
    do_reset();

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 1'b0, 1'b0);
    chk("fill_count",     64'(count),     64'd4);
    chk("fill_enq_ready", 64'(enq_ready), 64'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("drain_deq_valid", 64'(deq_valid), 64'h0);

    // Full queue with simultaneous dequeue: fetch still stalls.
    for (int i = 0; i < 4; i++) step(1'b1, 64'h20 + 64'(i * 4), 1'b0, 1'b0);
    step(1'b1, 64'h30, 1'b1, 1'b0);
    chk("full_deq_count", 64'(count), 64'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

    // Wrap-around: continuous enq+deq at occupancy 1.
    step(1'b1, 64'h100, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 64'h100 + 64'(i * 4), 1'b1, 1'b0);
      chk("wrap_count", 64'(count), 64'd1);
    end
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush with count=3 and a concurrent enqueue that must be dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 64'h80 + 64'(i * 4), 1'b0, 1'b0);
    step(1'b1, 64'h40, 1'b1, 1'b1);
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_flush_cnt", 64'(flush_cnt), 64'd1);
    for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

    // Same-cycle forwarding (or one-cycle latency when disabled).
    enq_valid = 1'b1; enq_pc = 64'h200; enq_instr = instr_of(64'h200); deq_ready = 1'b1;
    #3;
    chk("byp_deq_valid", 64'(deq_valid), 64'(BYP));
    chk("byp_deq_pc",    deq_pc,         BYP ? 64'h200 : 64'h0);
    @(posedge clk); #1;
    enq_valid = 1'b0;
    #3;
    chk("byp_next_count", 64'(count),     BYP ? 64'd0 : 64'd1);
    chk("byp_next_valid", 64'(deq_valid), BYP ? 64'h0 : 64'h1);
    @(posedge clk); #1;
    deq_ready = 1'b0;
    q.delete();
    #3;
    chk("byp_settled_count", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Reset mid-operation at count=2.
    step(1'b1, 64'h300, 1'b0, 1'b0);
    step(1'b1, 64'h304, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd2);
    do_reset();

    // Random mix of traffic, stalls and occasional flush.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 64'h1000 + 64'(i * 4), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    // flush_cnt saturation.
    do_reset();
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 64'(flush_cnt), 64'hFFFE);
    @(posedge clk); #1;
    chk("sat_ffff", 64'(flush_cnt), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 64'(flush_cnt), 64'hFFFF);
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
